// File: rtl/bit_reverser_pkg.sv
// Shared types and helpers for the FFT bit-reversed address generator.
package reverser_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rev_state_t;

  localparam int unsigned MAX_BITS = 16;

  // Reverse the low `width` bits of value; bits above width come back as zero.
  function automatic logic [MAX_BITS-1:0] bit_rev(input logic [MAX_BITS-1:0] value,
                                                  input int               width);
    logic [MAX_BITS-1:0] r;
    logic [MAX_BITS-1:0] sh;
    r = '0;
    for (int i = 0; i < MAX_BITS; i++) begin
      sh = value >> i;
      if (i < width) r = r | (MAX_BITS'(sh[0]) << (width - 1 - i));
    end
    return r;
  endfunction

endpackage

// File: rtl/bit_reverser_rev_comb.sv
// Purely combinational bit-reverse: rev[i] = fwd[WIDTH-1-i].
module bit_rev_comb #(
  parameter int unsigned WIDTH = 3
) (
  input  logic [WIDTH-1:0] fwd,
  output logic [WIDTH-1:0] rev
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign rev[i] = fwd[WIDTH-1-i];
  end

endmodule

// File: rtl/bit_reverser.sv
// Bit-reversed address generator: sweeps 0..2^BITS_PER_ROW-1 and its reverse.
// Optional addr_valid output under `REVERSER_VALID_EN.
module bit_reverser
  import reverser_pkg::*;
#(
  parameter int unsigned BITS_PER_ROW = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_gen,
  output logic [0:BITS_PER_ROW-1] addr,
  output logic [0:BITS_PER_ROW-1] addr_cnt,
`ifdef REVERSER_VALID_EN
  output logic                    addr_valid,
`endif
  output logic                    done_gen
);

  localparam int unsigned W = BITS_PER_ROW;

  if (W < 1 || W > MAX_BITS) begin : g_bad_width
    $error("bit_reverser: BITS_PER_ROW must be in 1..16");
  end

  rev_state_t     state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]   addr_q, rev_d;
  logic           done_q, done_d;
  logic           valid_q, valid_d;

  // Reverse the next count so addr is registered on the same edge as addr_cnt.
  bit_rev_comb #(.WIDTH(W)) u_rev (
    .fwd (cnt_d),
    .rev (rev_d)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start_gen) begin
          state_d = RUN;
          valid_d = 1'b1;
        end
      end
      RUN: begin
        // Last address reached: hold it rather than wrapping.
        if (&cnt_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + W'(1);
          valid_d = 1'b1;
        end
      end
      DONE: begin
        if (start_gen) begin
          done_d = 1'b1;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= rev_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  // Descending internal vectors map onto the ascending ports MSB-to-MSB.
  assign addr_cnt = cnt_q;
  assign addr     = addr_q;
  assign done_gen = done_q;
`ifdef REVERSER_VALID_EN
  assign addr_valid = valid_q;
`else
  logic unused_valid;
  assign unused_valid = valid_q;
`endif

endmodule

// File: tb/tb_bit_reverser.sv
// Self-checking bench for bit_reverser at widths 1, 3 and 4.
module tb_bit_reverser;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s1 = 1'b0, s3 = 1'b0, s4 = 1'b0;
  logic [0:0] a1, c1;
  logic [0:2] a3, c3;
  logic [0:3] a4, c4;
  logic d1, d3, d4;
`ifdef REVERSER_VALID_EN
  logic v1, v3, v4;
`endif

  int checks = 0;
  int errors = 0;

  bit_reverser #(.BITS_PER_ROW(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start_gen(s1), .addr(a1), .addr_cnt(c1),
`ifdef REVERSER_VALID_EN
    .addr_valid(v1),
`endif
    .done_gen(d1));

  bit_reverser #(.BITS_PER_ROW(3)) u_d3 (
    .clk(clk), .rst_n(rst_n), .start_gen(s3), .addr(a3), .addr_cnt(c3),
`ifdef REVERSER_VALID_EN
    .addr_valid(v3),
`endif
    .done_gen(d3));

  bit_reverser #(.BITS_PER_ROW(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .start_gen(s4), .addr(a4), .addr_cnt(c4),
`ifdef REVERSER_VALID_EN
    .addr_valid(v4),
`endif
    .done_gen(d4));

  always #50 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference reverse: read bits LSB-first, accumulate MSB-first.
  function automatic int rev_ref(input int v, input int w);
    int r = 0;
    for (int i = 0; i < w; i++) r = r * 2 + ((v >> i) & 1);
    return r;
  endfunction

  task automatic set_start(input int w, input logic v);
    case (w)
      1:       s1 = v;
      3:       s3 = v;
      default: s4 = v;
    endcase
  endtask

  task automatic chk_out(input int w, input string tag, input int e_cnt, input int e_addr,
                         input bit e_done, input bit e_valid);
    logic [31:0] oc, oa;
    logic        od, ov;
    case (w)
      1:       begin oc = 32'(c1); oa = 32'(a1); od = d1; end
      3:       begin oc = 32'(c3); oa = 32'(a3); od = d3; end
      default: begin oc = 32'(c4); oa = 32'(a4); od = d4; end
    endcase
    ov = 1'b0;
`ifdef REVERSER_VALID_EN
    case (w)
      1:       ov = v1;
      3:       ov = v3;
      default: ov = v4;
    endcase
    chk($sformatf("w%0d_%s_valid", w, tag), 32'(ov), 32'(e_valid));
`else
    if (ov !== 1'b0) $display("note: unexpected %0d", e_valid);
`endif
    chk($sformatf("w%0d_%s_cnt", w, tag), oc, e_cnt);
    chk($sformatf("w%0d_%s_addr", w, tag), oa, e_addr);
    chk($sformatf("w%0d_%s_done", w, tag), 32'(od), 32'(e_done));
  endtask

  // Drive start and walk the sweep; stops early after index `cut` (cut < 0: full sweep).
  // With jitter set, start_gen is randomised while running to show it is ignored.
  task automatic sweep(input int w, input int cut, input bit jitter);
    int n = 1 << w;
    set_start(w, 1'b1);
    for (int k = 0; k < n; k++) begin
      tick();
      chk_out(w, $sformatf("run%0d", k), k, rev_ref(k, w), 1'b0, 1'b1);
      if (k == cut) return;
      if (jitter) set_start(w, 1'($urandom_range(0, 1)));
    end
    tick();
    chk_out(w, "done", n - 1, n - 1, 1'b1, 1'b0);
  endtask

  task automatic hold_done(input int w, input int cycles);
    int n = 1 << w;
    set_start(w, 1'b1);
    repeat (cycles) begin
      tick();
      chk_out(w, "hold", n - 1, n - 1, 1'b1, 1'b0);
    end
  endtask

  task automatic release_start(input int w);
    set_start(w, 1'b0);
    tick();
    chk_out(w, "idle", 0, 0, 1'b0, 1'b0);
  endtask

  task automatic chk_all_idle(input string tag);
    chk_out(1, tag, 0, 0, 1'b0, 1'b0);
    chk_out(3, tag, 0, 0, 1'b0, 1'b0);
    chk_out(4, tag, 0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset held with start high must keep everything idle.
    rst_n = 1'b0; s1 = 1'b1; s3 = 1'b1; s4 = 1'b1;
    repeat (3) begin
      tick();
      chk_all_idle("rst");
    end
    s1 = 1'b0; s3 = 1'b0; s4 = 1'b0;
    rst_n = 1'b1;
    repeat ($urandom_range(1, 4)) begin
      tick();
      chk_all_idle("idle_lo");
    end

    // Basic sweep, long DONE hold with no auto-restart, then restart after one low cycle.
    sweep(3, -1, 1'b0);
    hold_done(3, $urandom_range(2, 6));
    release_start(3);
    sweep(3, -1, 1'b0);
    release_start(3);

    // Mid-sweep reset at count 3, release with start high.
    sweep(3, 3, 1'b0);
    rst_n = 1'b0;
    tick();
    chk_out(3, "midrst", 0, 0, 1'b0, 1'b0);
    rst_n = 1'b1;
    sweep(3, -1, 1'b0);
    release_start(3);

    // Random abort points and start jitter during RUN.
    repeat (3) begin
      sweep(3, $urandom_range(0, 6), 1'b1);
      rst_n = 1'b0;
      tick();
      chk_all_idle("rndrst");
      rst_n = 1'b1;
      release_start(3);
      sweep(3, -1, 1'b1);
      hold_done(3, $urandom_range(1, 3));
      release_start(3);
    end

    // Wider and narrowest widths.
    sweep(4, -1, 1'b0);
    hold_done(4, 2);
    release_start(4);
    sweep(4, -1, 1'b1);
    release_start(4);
    sweep(1, -1, 1'b0);
    hold_done(1, 2);
    release_start(1);
    chk_all_idle("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
